axi_ram: RTL and testbench

- Single-port-per-channel AXI4 slave memory model/RAM. It serves as the DRAM behind the prefetcher in the memory subsystem.
- Independent read (AR/R) and write (AW/W/B) engines share one storage array.
- Only incrementing and fixed bursts are supported. All responses are OKAY.

---
 rtl/axi_ram.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_ram.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram.sv
// AXI4 slave RAM: independent read and write burst engines over one shared word array.
// INCR and FIXED bursts only (WRAP/reserved behave as INCR); every response is OKAY.
module axi_ram #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int WORD_LSB = $clog2(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - WORD_LSB;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic { W_IDLE, W_BURST } w_state_t;
    typedef enum logic { R_IDLE, R_BURST } r_state_t;

    // Contents survive rst; only the power-up value is defined.
    logic [DATA_WIDTH-1:0] mem [2**WORD_AW] = '{default: '0};

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        if (burst == BURST_FIXED)
            return addr;
        return addr + (ADDR_WIDTH'(1) << size);
    endfunction

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

    // ---------------- write engine ----------------
    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_count;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  bvalid_reg;
    logic [ID_WIDTH-1:0]   bid_reg;
    logic                  aw_hs;
    logic                  w_hs;

    assign s_axi_awready = awready_reg && (!bvalid_reg || s_axi_bready);
    assign s_axi_wready  = wready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bid     = bid_reg;
    assign s_axi_bresp   = 2'b00;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && wready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            w_id        <= '0;
            w_addr      <= '0;
            w_count     <= '0;
            w_size      <= '0;
            w_burst     <= '0;
        end else begin
            if (bvalid_reg && s_axi_bready)
                bvalid_reg <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (aw_hs) begin
                        w_id        <= s_axi_awid;
                        w_addr      <= s_axi_awaddr;
                        w_count     <= s_axi_awlen;
                        w_size      <= s_axi_awsize;
                        w_burst     <= s_axi_awburst;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        w_state     <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (w_hs) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        if (w_count == 8'd0) begin
                            wready_reg  <= 1'b0;
                            awready_reg <= 1'b1;
                            bvalid_reg  <= 1'b1;
                            bid_reg     <= w_id;
                            w_state     <= W_IDLE;
                        end else begin
                            w_count <= w_count - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !rst) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i])
                    mem[w_addr[ADDR_WIDTH-1:WORD_LSB]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_count;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  arready_reg;

    // Stage 0 is the register loaded straight from the array.
    logic [DATA_WIDTH-1:0] r0_data;
    logic [ID_WIDTH-1:0]   r0_id;
    logic                  r0_last;
    logic                  r0_valid;
    logic                  r0_ready;
    logic                  r0_free;
    logic                  ar_hs;

    assign r0_free       = !r0_valid || r0_ready;
    assign s_axi_arready = arready_reg && r0_free;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign s_axi_rresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            arready_reg <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r0_data     <= '0;
            r0_id       <= '0;
            r0_last     <= 1'b0;
            r0_valid    <= 1'b0;
        end else begin
            if (r0_ready)
                r0_valid <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (ar_hs) begin
                        r_id        <= s_axi_arid;
                        r_addr      <= s_axi_araddr;
                        r_count     <= s_axi_arlen;
                        r_size      <= s_axi_arsize;
                        r_burst     <= s_axi_arburst;
                        arready_reg <= 1'b0;
                        r_state     <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r0_free) begin
                        r0_data  <= mem[r_addr[ADDR_WIDTH-1:WORD_LSB]];
                        r0_id    <= r_id;
                        r0_last  <= (r_count == 8'd0);
                        r0_valid <= 1'b1;
                        r_addr   <= next_addr(r_addr, r_size, r_burst);
                        if (r_count == 8'd0) begin
                            arready_reg <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_count <= r_count - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] r1_data;
            logic [ID_WIDTH-1:0]   r1_id;
            logic                  r1_last;
            logic                  r1_valid;

            // Output register refills whenever it is empty or being drained.
            assign r0_ready = !r1_valid || s_axi_rready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r1_data  <= '0;
                    r1_id    <= '0;
                    r1_last  <= 1'b0;
                    r1_valid <= 1'b0;
                end else if (r0_ready) begin
                    r1_data  <= r0_data;
                    r1_id    <= r0_id;
                    r1_last  <= r0_last;
                    r1_valid <= r0_valid;
                end
            end

            assign s_axi_rdata  = r1_data;
            assign s_axi_rid    = r1_id;
            assign s_axi_rlast  = r1_last;
            assign s_axi_rvalid = r1_valid;
        end else begin : g_direct
            assign r0_ready     = s_axi_rready;
            assign s_axi_rdata  = r0_data;
            assign s_axi_rid    = r0_id;
            assign s_axi_rlast  = r0_last;
            assign s_axi_rvalid = r0_valid;
        end
    endgenerate

endmodule

// File: tb/tb_axi_ram.sv
// Scoreboard bench for axi_ram (8-bit data, 16-bit address): stimulus pushes expected
// B/R responses computed from a byte-array model; a negedge monitor pops and compares.
module tb_axi_ram;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SW = 1;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [2:0]    s_axi_awsize = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [IW-1:0] s_axi_arid = '0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic [2:0]    s_axi_arsize = '0;
    logic [1:0]    s_axi_arburst = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;

    axi_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .PIPELINE_OUTPUT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
    } r_exp_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] ref_mem [65536] = '{default: 8'h00};
    r_exp_t     rq[$];
    logic [7:0] bq[$];
    logic [7:0] wdata_buf [256];
    logic       wstrb_buf [256];
    logic       hold_low = 1'b0;
    logic       rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of beat i under the AXI rules (FIXED stays put, others step by 2^size).
    function automatic logic [15:0] beat_addr(input logic [15:0] base, input int i,
                                              input logic [1:0] burst, input logic [2:0] size);
        if (burst == 2'b00)
            return base;
        return base + 16'(i * (1 << size));
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (hold_low)
            s_axi_rready = 1'b0;
        else if (rand_ready)
            s_axi_rready = ($urandom_range(0, 9) < 7);
        else
            s_axi_rready = 1'b1;
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] prev_id = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (s_axi_bvalid && s_axi_bready) begin
                check("b_expected", bq.size(), 1);
                if (bq.size() != 0) begin
                    check("bid", s_axi_bid, bq[0]);
                    check("bresp", s_axi_bresp, 2'b00);
                    void'(bq.pop_front());
                end
            end
            if (prev_stall) begin
                check("stall_rvalid", s_axi_rvalid, 1);
                check("stall_rdata", s_axi_rdata, prev_data);
                check("stall_rid", s_axi_rid, prev_id);
                check("stall_rlast", s_axi_rlast, prev_last);
            end
            if (rq.size() > 0 && !(s_axi_rvalid && s_axi_rready && s_axi_rlast))
                check("arready_busy", s_axi_arready, 0);
            if (s_axi_rvalid && s_axi_rready) begin
                check("r_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    check("rdata", s_axi_rdata, rq[0].data);
                    check("rid", s_axi_rid, rq[0].id);
                    check("rlast", s_axi_rlast, rq[0].last);
                    check("rresp", s_axi_rresp, 2'b00);
                    void'(rq.pop_front());
                end
            end
            prev_stall <= s_axi_rvalid && !s_axi_rready;
            prev_data  <= s_axi_rdata;
            prev_id    <= s_axi_rid;
            prev_last  <= s_axi_rlast;
        end
    end

    task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size);
        int n;
        logic [15:0] a;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 100) begin @(posedge clk); #1; n++; end
        check("aw_accept", n < 100, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        check("awready_drop", s_axi_awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = wdata_buf[i]; s_axi_wstrb = wstrb_buf[i];
            s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 100) begin @(posedge clk); #1; n++; end
            check("w_accept", n < 100, 1);
            @(posedge clk); #1;
            a = beat_addr(addr, i, burst, size);
            if (wstrb_buf[i])
                ref_mem[a] = wdata_buf[i];
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check("b_latency", s_axi_bvalid, 1);
        bq.push_back(id);
        n = 0;
        while (bq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("b_done", bq.size(), 0);
        bq.delete();
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n;
        logic [15:0] a;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 100) begin @(posedge clk); #1; n++; end
        check("ar_accept", n < 100, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, burst, size);
            rq.push_back(r_exp_t'{data: ref_mem[a], id: id, last: (i == int'(len))});
        end
        check("r_latency_early", s_axi_rvalid, 0);
        @(posedge clk); #1;
        check("r_latency", s_axi_rvalid, 1);
        n = 0;
        while (rq.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        check("r_done", rq.size(), 0);
        rq.delete();
    endtask

    initial begin
        int n;
        logic [15:0] ra;
        logic [7:0]  rl;
        logic [1:0]  rb;
        logic [2:0]  rs;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single beat write/read
        wdata_buf[0] = 8'hA5; wstrb_buf[0] = 1'b1;
        axi_write(8'd5, 16'h0EEF, 8'd0, 2'b01, 3'd0);
        axi_read(8'd5, 16'h0EEF, 8'd0, 2'b01, 3'd0);

        // INCR burst
        for (int i = 0; i < 4; i++) begin wdata_buf[i] = 8'(i + 1); wstrb_buf[i] = 1'b1; end
        axi_write(8'd1, 16'h0010, 8'd3, 2'b01, 3'd0);
        axi_read(8'd2, 16'h0010, 8'd3, 2'b01, 3'd0);

        // back-pressure mid-burst
        fork
            axi_read(8'd3, 16'h0010, 8'd3, 2'b01, 3'd0);
            begin
                repeat (3) @(posedge clk);
                hold_low = 1'b1;
                repeat (5) @(posedge clk);
                hold_low = 1'b0;
            end
        join

        // FIXED burst: last beat wins, neighbour untouched
        wdata_buf[0] = 8'h11; wdata_buf[1] = 8'h22; wstrb_buf[0] = 1'b1; wstrb_buf[1] = 1'b1;
        axi_write(8'd4, 16'h0020, 8'd1, 2'b00, 3'd0);
        axi_read(8'd4, 16'h0020, 8'd1, 2'b01, 3'd0);

        // zero strobe leaves memory unchanged
        wdata_buf[0] = 8'hFF; wstrb_buf[0] = 1'b0;
        axi_write(8'd6, 16'h0EEF, 8'd0, 2'b01, 3'd0);
        axi_read(8'd6, 16'h0EEF, 8'd0, 2'b01, 3'd0);

        // address wraps past the top of memory; WRAP burst type acts as INCR
        for (int i = 0; i < 4; i++) begin wdata_buf[i] = 8'(8'hC0 + i); wstrb_buf[i] = 1'b1; end
        axi_write(8'd7, 16'hFFFE, 8'd3, 2'b10, 3'd0);
        axi_read(8'd8, 16'hFFFE, 8'd3, 2'b01, 3'd0);

        // reset in the middle of a stalled read burst
        hold_low = 1'b1;
        @(posedge clk); #1;
        s_axi_arid = 8'd9; s_axi_araddr = 16'h0010; s_axi_arlen = 8'd7;
        s_axi_arburst = 2'b01; s_axi_arsize = 3'd0; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 100) begin @(posedge clk); #1; n++; end
        check("rst_ar_accept", n < 100, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_rvalid", s_axi_rvalid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_rvalid", s_axi_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_low = 1'b0;
        @(posedge clk); #1;
        axi_read(8'd10, 16'h0010, 8'd3, 2'b01, 3'd0);

        // randomized bursts with random back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            ra = 16'($urandom);
            rl = 8'($urandom_range(0, 15));
            rb = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 2));
            for (int i = 0; i <= int'(rl); i++) begin
                wdata_buf[i] = 8'($urandom);
                wstrb_buf[i] = ($urandom_range(0, 4) != 0);
            end
            axi_write(8'($urandom), ra, rl, rb, rs);
            axi_read(8'($urandom), ra, rl, rb, rs);
            axi_read(8'($urandom), ra - 16'd2, 8'($urandom_range(0, 20)), 2'b01, 3'd0);
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
